// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-PC constants and the sequencer state type, also used by the
// exception unit and the bench.
package pc_sequencer_pkg;

  localparam int unsigned     PC_WIDTH      = 32;
  localparam int unsigned     PC_STEP       = 4;
  localparam logic [31:0]     PC_RESET      = 32'h0000_3000;
  localparam logic [31:0]     PC_EXC_VECTOR = 32'h0000_4180;
  localparam int unsigned     PC_ALIGN_BITS = 2;

  // HELD means a redirect arrived under stall and is waiting in the buffer
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_adder.sv
// Modulo-2^WIDTH sequential increment shared by the link output and the
// PC update path.
module pc_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + WIDTH'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: holds on stall, buffers redirects that
// arrive while stalled, and handles exception entry and ERET return.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       WIDTH      = PC_WIDTH,
  parameter int unsigned       STEP       = PC_STEP,
  parameter logic [WIDTH-1:0]  RESET_PC   = WIDTH'(PC_RESET),
  parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'(PC_EXC_VECTOR),
  parameter int unsigned       ALIGN_BITS = PC_ALIGN_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pending,
  output logic             misaligned
);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] pc_nxt;
  logic             buffer_load;

  pc_adder #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_adder (
    .a   (pc),
    .sum (pc_plus_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (exc_req || eret_req) begin
      state_nxt = IDLE;
    end else if (stall) begin
      if (redirect_valid) begin
        state_nxt = HELD;
      end
    end else begin
      state_nxt = IDLE;
    end
  end

  // Output logic
  always_comb begin
    pending = (state == HELD);
  end

  assign buffer_load = !exc_req && !eret_req && stall && redirect_valid;

  always_comb begin
    pc_nxt = pc_plus_step;
    if (exc_req) begin
      pc_nxt = EXC_VECTOR;
    end else if (eret_req) begin
      pc_nxt = epc;
    end else if (stall) begin
      pc_nxt = pc;
    end else if (redirect_valid) begin
      pc_nxt = redirect_target;
    end else if (pending) begin
      pc_nxt = pend_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      pend_target <= '0;
    end else begin
      pc <= pc_nxt;
      if (buffer_load) begin
        pend_target <= redirect_target;
      end
    end
  end

  assign misaligned = |pc[ALIGN_BITS-1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model pushes the expected
// PC/pending per driven cycle; they are popped and compared after the edge.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, exc_req, eret_req;
  logic [31:0] redirect_target, epc;
  logic [31:0] pc, pc_plus_step;
  logic        pending, misaligned;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc   = '0;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt  = '0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH      (32),
    .STEP       (4),
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .ALIGN_BITS (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .pc              (pc),
    .pc_plus_step    (pc_plus_step),
    .pending         (pending),
    .misaligned      (misaligned)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the reference model, then score the DUT outputs
  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rt,
                      input logic ex, input logic er, input logic [31:0] ep);
    exp_t e;
    exp_t o;
    reset = rst; stall = st; redirect_valid = rv; redirect_target = rt;
    exc_req = ex; eret_req = er; epc = ep;
    if (!rst) begin
      m_pc = 32'h0000_3000; m_pend = 1'b0; m_tgt = '0;
    end else if (ex) begin
      m_pc = 32'h0000_4180; m_pend = 1'b0;
    end else if (er) begin
      m_pc = ep; m_pend = 1'b0;
    end else if (st) begin
      if (rv) begin
        m_tgt = rt; m_pend = 1'b1;
      end
    end else if (rv) begin
      m_pc = rt; m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.pend = m_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      check_val("pc", pc, o.pc);
      check_val("pending", {31'd0, pending}, {31'd0, o.pend});
      check_val("pc_plus_step", pc_plus_step, o.pc + 32'd4);
      check_val("misaligned", {31'd0, misaligned}, {31'd0, |o.pc[1:0]});
    end
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;

    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check_val("reset_pc", pc, 32'h0000_3000);
    check_val("reset_pps", pc_plus_step, 32'h0000_3004);
    idle_step(); idle_step(); idle_step();
    check_val("free_run", pc, 32'h0000_300C);

    // Buffered redirect across a two-cycle stall
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    idle_step(); idle_step();
    step(1'b1, 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, '0);
    check_val("stall_hold", pc, 32'h0000_3008);
    check_val("stall_pend", {31'd0, pending}, 32'd1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    idle_step();
    check_val("release", pc, 32'h0000_3100);
    idle_step();
    check_val("after_release", pc, 32'h0000_3104);

    // Latest stalled redirect wins
    step(1'b1, 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h3200, 1'b0, 1'b0, '0);
    idle_step();
    check_val("latest_wins", pc, 32'h0000_3200);

    // Live redirect beats buffered one
    step(1'b1, 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h3300, 1'b0, 1'b0, '0);
    check_val("live_wins", pc, 32'h0000_3300);

    // Exception beats ERET, stall and pending
    step(1'b1, 1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h3050);
    check_val("exc_pc", pc, 32'h0000_4180);
    check_val("exc_pend", {31'd0, pending}, 32'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h3050);
    check_val("eret_pc", pc, 32'h0000_3050);
    idle_step();

    // ERET under stall with a buffered redirect
    step(1'b1, 1'b1, 1'b1, 32'h3600, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h3700, 1'b0, 1'b1, 32'h3060);
    check_val("eret_stall", pc, 32'h0000_3060);
    idle_step();

    // Misaligned target and wraparound
    step(1'b1, 1'b0, 1'b1, 32'h3102, 1'b0, 1'b0, '0);
    check_val("misaligned", {31'd0, misaligned}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0);
    check_val("misaligned_clr", {31'd0, misaligned}, 32'd0);
    idle_step();
    check_val("wrap", pc, 32'h0000_0000);

    // Reset while pending clears the buffer
    step(1'b1, 1'b1, 1'b1, 32'h3500, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_val("rst_pend_pc", pc, 32'h0000_3000);
    check_val("rst_pend_flag", {31'd0, pending}, 32'd0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    idle_step();
    check_val("rst_release", pc, 32'h0000_3004);

    // Random mix against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] rt;
      rt = 32'h0000_3000 + ($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 7) == 0);
      step($urandom_range(0, 31) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, rt,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           32'h0000_3800 + ($urandom_range(0, 63) << 2));
    end

    if (sb.size() != 0) check_val("sb_leftover", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the fetch stage of the MIPS pipeline. It replaces a bare PC+4 adder plus separate PC register with one block that owns the PC register. It holds the PC on stall and applies branch/jump redirects, exception entry and ERET return. A redirect that arrives during a stall is buffered and applied when the stall releases, so no control transfer is lost.

Parameters:
WIDTH, 32, PC width in bits
STEP, 4, sequential increment added to PC each non-stalled cycle
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VECTOR, 32'h0000_4180, exception handler entry address
ALIGN_BITS, 2, number of low PC bits that must be zero for an aligned fetch

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 at posedge = reset)
stall  input  1  hold PC (fetch stage stalled)
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  WIDTH  branch/jump destination
exc_req  input  1  exception/interrupt entry request
eret_req  input  1  return from exception
epc  input  WIDTH  return address for ERET
pc  output  WIDTH  current fetch PC (registered)
pc_plus_step  output  WIDTH  pc + STEP, combinational; used for link register
pending  output  1  a buffered redirect is waiting (registered)
misaligned  output  1  combinational; pc[ALIGN_BITS-1:0] != 0

Behaviour:
- Reset (reset==0 at posedge): pc <= RESET_PC; pending <= 0; pend_target <= 0. After reset: pc_plus_step = RESET_PC+STEP, misaligned = 0 (for default parameters).
- Priority at each posedge with reset==1, highest first:
  1. exc_req: pc <= EXC_VECTOR; pending <= 0. Overrides stall, eret_req and redirect.
  2. eret_req: pc <= epc; pending <= 0. Overrides stall and redirect.
  3. stall==1: pc holds. If redirect_valid, pend_target <= redirect_target and pending <= 1. A later stalled redirect overwrites the buffer (latest wins).
  4. stall==0 and redirect_valid: pc <= redirect_target; pending <= 0. A live redirect beats the buffered one.
  5. stall==0 and pending: pc <= pend_target; pending <= 0.
  6. Otherwise: pc <= pc + STEP.
- Latency: a redirect, exception or ERET is visible on pc one cycle after the request edge. A buffered redirect is visible one cycle after the first non-stalled edge.
- Arithmetic: pc + STEP is modulo 2^WIDTH, so all-ones minus 3 wraps to 0. No carry out.
- Targets are loaded unmodified, with no masking. A misaligned target sets misaligned while that PC is current; trapping on it is the core's job.
- States: two, IDLE (pending=0) and HELD (pending=1).
  - IDLE -> HELD on stall & redirect_valid with no exc/eret.
  - HELD -> IDLE on exc_req, eret_req, or stall==0.
- Reset asserted while pending=1 clears the buffer. The buffered target is never applied after reset.
- exc_req and eret_req together: the exception wins and ERET is dropped.

Decomposition:
- Shared package: WIDTH default, RESET_PC, EXC_VECTOR, STEP constants, also used by the exception unit and the testbench.
- One sub-module, pc_adder (parametrised WIDTH, STEP, combinational), instantiated once. Its output drives both pc_plus_step and the increment path.

Test Plan:
- Reset, then 3 free-running cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_plus_step = pc+4.
- Stall high 2 cycles at pc=0x3008 with redirect_valid, target 0x3100 in the first stall cycle -> pc stays 0x3008 and pending=1. First unstalled edge gives pc=0x3100, pending=0; the next edge gives 0x3104.
- Stalled redirects to 0x3100 then 0x3200, then release -> pc=0x3200. Second scenario: buffered 0x3100 with a live redirect to 0x3300 on the release cycle -> pc=0x3300.
- exc_req and eret_req together, with stall=1, pending=1 and epc=0x3050 -> pc=0x4180, pending=0. Next cycle eret_req alone -> pc=0x3050.
- Redirect to 0x3102 -> misaligned=1 while pc=0x3102. With STEP=4, pc=0xFFFF_FFFC increments to 0x0000_0000.
- Reset asserted mid-stall with pending=1 -> next pc=0x3000, pending=0. After release, increments from 0x3000.
